// File: rtl/kernel_scale_arbiter_if.sv
// rtl/kernel_scale_arbiter_if.sv - request, config, scaler and result signals of kernel_scale_arbiter
`ifndef BIT_DATA
`define BIT_DATA 8
`endif

interface kernel_scale_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int BIT_IN = 16,
  parameter int BIT_SH = $clog2(BIT_IN - `BIT_DATA),
  parameter int TAG_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*BIT_IN-1:0] req_x;
  logic [N_REQ-1:0]        req_ready;
  logic                    cfg_we;
  logic [TAG_W-1:0]        cfg_idx;
  logic [BIT_SH-1:0]       cfg_scale;
  logic [BIT_IN-1:0]       sc_x;
  logic [BIT_SH-1:0]       sc_scale;
  logic [`BIT_DATA-1:0]    sc_y;
  logic                    out_valid;
  logic [`BIT_DATA-1:0]    out_y;
  logic [TAG_W-1:0]        out_tag;
  logic                    out_ready;
  logic                    busy;

  // Environment side: requesters, config master, external scaler, downstream consumer.
  modport master (
    output req_valid, req_x, cfg_we, cfg_idx, cfg_scale, sc_y, out_ready,
    input  req_ready, sc_x, sc_scale, out_valid, out_y, out_tag, busy
  );

  modport slave (
    input  req_valid, req_x, cfg_we, cfg_idx, cfg_scale, sc_y, out_ready,
    output req_ready, sc_x, sc_scale, out_valid, out_y, out_tag, busy
  );
endinterface

// File: rtl/kernel_scale_arbiter.sv
// rtl/kernel_scale_arbiter.sv - round-robin sharing of one kernel_scale between N_REQ accumulators
// Optional round-half-up with positive saturation when KERNEL_SCALE_ROUND_EN is defined.
`ifndef BIT_DATA
`define BIT_DATA 8
`endif

module kernel_scale_arbiter #(
  parameter int N_REQ  = 4,
  parameter int BIT_IN = 16,
  parameter int BIT_SH = $clog2(BIT_IN - `BIT_DATA),
  parameter int TAG_W  = $clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  kernel_scale_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCALE, LOAD, OUT} state_t;
  state_t state, state_nx;

  logic [BIT_SH-1:0]    scale_tbl [N_REQ];
  logic [BIT_IN-1:0]    xs [N_REQ];
  logic [TAG_W-1:0]     ptr, tag, win;
  logic                 found, accept;
  int                   cand;
  logic [N_REQ-1:0]     grant;
  logic [BIT_IN-1:0]    x_sel, operand;
  logic [BIT_SH-1:0]    scale_sel;
  logic [BIT_IN-1:0]    sc_x_r;
  logic [BIT_SH-1:0]    sc_scale_r;
  logic                 out_valid_r;
  logic [`BIT_DATA-1:0] out_y_r;
  logic [TAG_W-1:0]     out_tag_r;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) xs[i] = bus.req_x[i*BIT_IN +: BIT_IN];
  end

  // Search starts one past the last winner, so the previous owner gets lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && bus.req_valid[TAG_W'(cand)]) begin
        found = 1'b1;
        win   = TAG_W'(cand);
      end
    end
    grant = '0;
    if (state == IDLE && found) grant[win] = 1'b1;
    accept    = |(grant & bus.req_valid);
    x_sel     = xs[win];
    scale_sel = scale_tbl[win];
  end

`ifdef KERNEL_SCALE_ROUND_EN
  localparam logic signed [BIT_IN:0] MAX_POS = (BIT_IN+1)'(2**(BIT_IN-1) - 1);
  logic [BIT_IN:0]        rinc;
  logic signed [BIT_IN:0] rsum;

  always_comb begin
    rinc = '0;
    if (scale_sel != '0) rinc = (BIT_IN+1)'(1) << (scale_sel - 1'b1);
    rsum    = $signed({x_sel[BIT_IN-1], x_sel}) + $signed(rinc);
    operand = (rsum > MAX_POS) ? MAX_POS[BIT_IN-1:0] : rsum[BIT_IN-1:0];
  end
`else
  always_comb begin
    operand = x_sel;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SCALE;
      SCALE:   state_nx = LOAD;
      LOAD:    state_nx = OUT;
      OUT:     if (out_valid_r && bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Table lookup happens before this edge's write lands, so a same-edge write only affects later operands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++) scale_tbl[i] <= '0;
      ptr         <= TAG_W'(N_REQ - 1);
      tag         <= '0;
      sc_x_r      <= '0;
      sc_scale_r  <= '0;
      out_valid_r <= 1'b0;
      out_y_r     <= '0;
      out_tag_r   <= '0;
    end else begin
      if (bus.cfg_we) scale_tbl[bus.cfg_idx] <= bus.cfg_scale;
      if (accept) begin
        sc_x_r     <= operand;
        sc_scale_r <= scale_sel;
        tag        <= win;
        ptr        <= win;
      end
      if (state == LOAD) begin
        out_y_r     <= bus.sc_y;
        out_tag_r   <= tag;
        out_valid_r <= 1'b1;
      end else if (state == OUT && out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.sc_x      = sc_x_r;
  assign bus.sc_scale  = sc_scale_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_tag   = out_tag_r;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_kernel_scale_arbiter.sv
// tb/tb_kernel_scale_arbiter.sv - bench for kernel_scale_arbiter with a transaction-level reference model
module tb_kernel_scale_arbiter;
  localparam int N_REQ = 4, BIT_IN = 16, BIT_SH = 3, TAG_W = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  kernel_scale_arbiter_if #(.N_REQ(N_REQ), .BIT_IN(BIT_IN), .BIT_SH(BIT_SH), .TAG_W(TAG_W)) bus ();

  kernel_scale_arbiter #(.N_REQ(N_REQ), .BIT_IN(BIT_IN), .BIT_SH(BIT_SH), .TAG_W(TAG_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // External scaler: one registered arithmetic shift, low 8 bits kept.
  logic [7:0] scaler_y;
  always @(posedge clock) scaler_y <= 8'($signed(bus.sc_x) >>> bus.sc_scale);
  assign bus.sc_y = scaler_y;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: one transaction in flight, result visible from two edges after its accept.
  bit         m_busy;
  int         m_age;
  int         m_last;
  int         m_tag;
  logic [7:0] m_y;
  int         m_tbl [N_REQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_scale(input int x, input int s);
    int v;
    v = x;
`ifdef KERNEL_SCALE_ROUND_EN
    if (s > 0) begin
      v = x + (1 << (s - 1));
      if (v > 32767) v = 32767;
    end
`endif
    return 8'(v >>> s);
  endfunction

  function automatic int pick();
    for (int k = 1; k <= N_REQ; k++) begin
      int c;
      c = (m_last + k) % N_REQ;
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_last = N_REQ - 1;
    m_tag  = 0;
    m_y    = '0;
    for (int i = 0; i < N_REQ; i++) m_tbl[i] = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    int w;
    logic [3:0] er;
    #1;
    w  = pick();
    er = (!m_busy && w >= 0) ? 4'(1 << w) : 4'b0;
    check("req_ready", bus.req_ready, er);
    check("busy", bus.busy, m_busy);
    check("out_valid", bus.out_valid, (m_busy && m_age >= 2));
    if (m_busy && m_age >= 2) begin
      check("out_y", bus.out_y, m_y);
      check("out_tag", bus.out_tag, m_tag);
    end
    @(posedge clock);
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_tag  = w;
        m_last = w;
        m_y    = ref_scale($signed(bus.req_x[w*16 +: 16]), m_tbl[w]);
      end
    end else if (m_age >= 2) begin
      if (bus.out_ready) m_busy = 1'b0;
    end else begin
      m_age++;
    end
    if (bus.cfg_we) m_tbl[bus.cfg_idx] = bus.cfg_scale;
    @(negedge clock);
  endtask

  task automatic wait_valid(input string tag, output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 12) begin
      step();
      edges++;
    end
    check(tag, bus.out_valid, 1'b1);
  endtask

  task automatic apply_reset();
    bus.req_valid = '0;
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_y", bus.out_y, 8'h00);
    check("rst_out_tag", bus.out_tag, 2'd0);
    check("rst_req_ready", bus.req_ready, 4'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_sc_x", bus.sc_x, 16'h0);
    check("rst_sc_scale", bus.sc_scale, 3'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic cfg(input int idx, input int s);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 2'(idx);
    bus.cfg_scale = 3'(s);
    step();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    int e;
    int gq[$];
    int gt[$];
    int tq[$];
    logic [7:0] y0;
    logic [7:0] exp6;

    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_scale = '0;
    bus.out_ready = 1'b1;
    model_reset();
    @(negedge clock);
    apply_reset();

    // Single request, scale 3: 200 >>> 3 = 25, visible on the third edge counting the accept.
    cfg(1, 3);
    bus.req_valid = 4'b0010;
    bus.req_x[16 +: 16] = 16'd200;
    step();
    bus.req_valid = '0;
    wait_valid("t1_valid", e);
    check("t1_latency", e + 1, 3);
    check("t1_y", bus.out_y, 8'd25);
    check("t1_tag", bus.out_tag, 2'd1);
    step();

    // All requesters valid: fair rotation from requester 0, one grant per 4 cycles.
    apply_reset();
    for (int i = 0; i < N_REQ; i++) bus.req_x[i*16 +: 16] = 16'(i);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (bus.req_ready != 4'b0) begin
        gq.push_back(onehot_idx(bus.req_ready));
        gt.push_back(c);
      end
      if (bus.out_valid) tq.push_back(int'(bus.out_tag));
      step();
    end
    bus.req_valid = '0;
    check("t2_ngrant", gq.size() >= 5, 1'b1);
    check("t2_ntag", tq.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t2_grant", gq[i], i % N_REQ);
      check("t2_tag", tq[i], i % N_REQ);
    end
    check("t2_period", gt[4] - gt[0], 16);
    while (bus.busy) step();

    // Downstream stall: result held, no grants, busy stays high.
    apply_reset();
    bus.req_x[0 +: 16]  = 16'd100;
    bus.req_x[16 +: 16] = 16'd50;
    bus.req_valid = 4'b0011;
    bus.out_ready = 1'b0;
    step();
    wait_valid("t3_valid", e);
    y0 = bus.out_y;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold_y", bus.out_y, y0);
      check("t3_hold_tag", bus.out_tag, 2'd0);
      check("t3_busy", bus.busy, 1'b1);
    end
    bus.out_ready = 1'b1;
    step();
    #1;
    check("t3_next_grant", bus.req_ready, 4'b0010);
    bus.req_valid = '0;
    step();
    while (bus.busy) step();

    // Table write on the accepting edge: the accept still uses the old shift.
    apply_reset();
    cfg(2, 1);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 2'd2;
    bus.cfg_scale = 3'd2;
    bus.req_valid = 4'b0100;
    bus.req_x[32 +: 16] = 16'hFFF8;
    step();
    bus.cfg_we    = 1'b0;
    bus.req_valid = '0;
    wait_valid("t4a_valid", e);
    check("t4_old_scale", bus.out_y, 8'hFC);
    step();
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    wait_valid("t4b_valid", e);
    check("t4_new_scale", bus.out_y, 8'hFE);
    step();

    // Rounding and saturation only differ with the rounding build.
`ifdef KERNEL_SCALE_ROUND_EN
    exp6 = 8'd2;
`else
    exp6 = 8'd1;
`endif
    apply_reset();
    cfg(0, 2);
    bus.req_valid = 4'b0001;
    bus.req_x[0 +: 16] = 16'd6;
    step();
    bus.req_valid = '0;
    wait_valid("t5a_valid", e);
    check("t5_round", bus.out_y, exp6);
    step();
    bus.req_valid = 4'b0001;
    bus.req_x[0 +: 16] = 16'd32767;
    step();
    bus.req_valid = '0;
    wait_valid("t5b_valid", e);
    check("t5_sat", bus.out_y, 8'hFF);
    step();

    // Reset in LOAD: result dropped, table cleared, pointer back to requester 0 first.
    apply_reset();
    cfg(3, 5);
    bus.req_valid = 4'b1000;
    bus.req_x[48 +: 16] = 16'd64;
    step();
    bus.req_valid = '0;
    step();
    apply_reset();
    check("t6_no_valid", bus.out_valid, 1'b0);
    bus.req_valid = 4'b1111;
    #1;
    check("t6_first_grant", bus.req_ready, 4'b0001);
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = '0;
    wait_valid("t6_valid", e);
    check("t6_table_cleared", bus.out_y, 8'h40);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N_REQ; i++) begin
        bus.req_x[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32760, 32767))
                                                              : 16'($urandom);
      end
      bus.cfg_we    = ($urandom_range(0, 3) == 0);
      bus.cfg_idx   = 2'($urandom_range(0, 3));
      bus.cfg_scale = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
